video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-enable divider, h/v counters, one-pixel
// fetch pipeline and registered sync/blank/colour outputs.
module video_timing_gen #(
    parameter int CLK_DIV      = 4,
    parameter int H_TOTAL      = 384,
    parameter int H_ACTIVE     = 288,
    parameter int H_SYNC_START = 304,
    parameter int H_SYNC_LEN   = 32,
    parameter int V_TOTAL      = 264,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_LEN   = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    output logic       en_vid,
    output logic       pix_req,
    output logic [8:0] pix_x,
    output logic [8:0] pix_y,
    input  logic [3:0] pix_r,
    input  logic [3:0] pix_g,
    input  logic [3:0] pix_b,
    output logic       hs_out,
    output logic       vs_out,
    output logic [3:0] r_out,
    output logic [3:0] g_out,
    output logic [3:0] b_out,
    output logic       hblank,
    output logic       vblank
);

    localparam logic [4:0] DIV_MAX = 5'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_SYNC_START);
    localparam logic [9:0] HS_END  = 10'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [9:0] VS_BEG  = 10'(V_SYNC_START);
    localparam logic [9:0] VS_END  = 10'(V_SYNC_START + V_SYNC_LEN);

    logic [4:0] div_q, div_d;
    logic       en_q, en_d;
    logic       run_q, run_d;
    logic [8:0] hcnt_q, hcnt_d;
    logic [8:0] vcnt_q, vcnt_d;
    logic [8:0] s1_h_q, s1_h_d;
    logic [8:0] s1_v_q, s1_v_d;
    logic       s1_act_q, s1_act_d;
    logic       s1_vld_q, s1_vld_d;
    logic [3:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       hs_q, hs_d, vs_q, vs_d;
    logic       hb_q, hb_d, vb_q, vb_d;

    logic       tick;
    logic       active;
    logic [9:0] h_w, v_w, s1h_w, s1v_w;

    assign h_w   = {1'b0, hcnt_q};
    assign v_w   = {1'b0, vcnt_q};
    assign s1h_w = {1'b0, s1_h_q};
    assign s1v_w = {1'b0, s1_v_q};

    // Counters step on the edge that opens an en_vid cycle, so the
    // requested coordinate is stable from that cycle until the next one.
    always_comb begin
        tick   = (div_q == DIV_MAX);
        div_d  = tick ? 5'd0 : div_q + 5'd1;
        en_d   = tick;
        run_d  = run_q | tick;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (tick && run_q) begin
            if (h_w == H_LAST) begin
                hcnt_d = 9'd0;
                vcnt_d = (v_w == V_LAST) ? 9'd0 : vcnt_q + 9'd1;
            end else begin
                hcnt_d = hcnt_q + 9'd1;
            end
        end
    end

    assign active = (h_w < H_ACT) && (v_w < V_ACT);

    always_comb begin
        s1_h_d   = s1_h_q;
        s1_v_d   = s1_v_q;
        s1_act_d = s1_act_q;
        s1_vld_d = s1_vld_q;
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        hs_d = hs_q;
        vs_d = vs_q;
        hb_d = hb_q;
        vb_d = vb_q;
        if (en_q) begin
            s1_h_d   = hcnt_q;
            s1_v_d   = vcnt_q;
            s1_act_d = active;
            s1_vld_d = 1'b1;
            if (s1_vld_q) begin
                r_d  = s1_act_q ? pix_r : 4'd0;
                g_d  = s1_act_q ? pix_g : 4'd0;
                b_d  = s1_act_q ? pix_b : 4'd0;
                hb_d = (s1h_w >= H_ACT);
                vb_d = (s1v_w >= V_ACT);
                hs_d = !((s1h_w >= HS_BEG) && (s1h_w < HS_END));
                // vsync only moves together with the hsync falling edge
                if (s1h_w == HS_BEG) begin
                    vs_d = !((s1v_w >= VS_BEG) && (s1v_w < VS_END));
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_q    <= 5'd0;
            en_q     <= 1'b0;
            run_q    <= 1'b0;
            hcnt_q   <= 9'd0;
            vcnt_q   <= 9'd0;
            s1_h_q   <= 9'd0;
            s1_v_q   <= 9'd0;
            s1_act_q <= 1'b0;
            s1_vld_q <= 1'b0;
            r_q      <= 4'd0;
            g_q      <= 4'd0;
            b_q      <= 4'd0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            hb_q     <= 1'b1;
            vb_q     <= 1'b1;
        end else begin
            div_q    <= div_d;
            en_q     <= en_d;
            run_q    <= run_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            s1_h_q   <= s1_h_d;
            s1_v_q   <= s1_v_d;
            s1_act_q <= s1_act_d;
            s1_vld_q <= s1_vld_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            hb_q     <= hb_d;
            vb_q     <= vb_d;
        end
    end

    assign en_vid  = en_q;
    assign pix_req = en_q & active;
    assign pix_x   = hcnt_q;
    assign pix_y   = vcnt_q;
    assign hs_out  = hs_q;
    assign vs_out  = vs_q;
    assign r_out   = r_q;
    assign g_out   = g_q;
    assign b_out   = b_q;
    assign hblank  = hb_q;
    assign vblank  = vb_q;

endmodule
